mem_port_arbiter: RTL and testbench

Arbitrates the single-port `main_memory` between the instruction-fetch requester (stage sequencer / issue register) and the data requester (load/store path). Grants at most one access per cycle, drives the memory's read/write ports, and routes one-cycle-latency read data back to the owning requester. It sits between the CPU stage control and `main_memory`, replacing the fixed `read_address = PC` wiring.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Owner of the read issued on the previous cycle; doubles as the
  // read-owner FSM state of mem_port_arbiter.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } mem_owner_t;

  // main_memory returns read data this many cycles after the address.
  localparam int unsigned MEM_RD_LATENCY = 1;

endpackage : cpu_pkg

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: the loser of a conflict is simply not granted and keeps its request.
// Ports: if_req/d_req in; last_d_won in (only with MEM_ARB_ROUND_ROBIN_EN);
//        if_gnt/d_gnt out, one-hot or both 0.
// Config: MEM_ARB_ROUND_ROBIN_EN selects alternating conflict winner,
//         otherwise data always wins.
module mem_arb_pick (
  input  logic if_req,
  input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_d_won,  // 1: data won the previous conflict
`endif
  output logic if_gnt,
  output logic d_gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On conflict, data wins only if fetch won the previous conflict.
  assign d_gnt = d_req & (~if_req | ~last_d_won);
`else
  assign d_gnt = d_req;
`endif

  // Fetch gets the port whenever data does not take it.
  assign if_gnt = if_req & ~d_gnt;

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Arbitrates single-port main_memory between instruction fetch and data requesters.
// Latency: grant same cycle as request; read data valid exactly one cycle after grant.
// Backpressure: an ungranted requester holds its request; nothing is dropped or reordered.
// Ports: clk, rst (async active-low); if_req/if_addr -> if_gnt, if_rvalid/if_rdata;
//        d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid/d_rdata;
//        mem_read_address/mem_write_address/mem_write_data/mem_write_enable to memory,
//        mem_read_data from memory; busy = read in flight.
// Config: define MEM_ARB_ROUND_ROBIN_EN for alternating conflict winner (first to data);
//         default build is fixed priority with data winning conflicts.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  mem_owner_t state, state_nxt;
  logic       if_gnt_raw, d_gnt_raw;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d_won;

  // Only conflicts move the policy bit; reset value means "fetch won last",
  // so the first conflict after reset goes to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_won <= 1'b0;
    end else if (if_req && d_req) begin
      last_d_won <= d_gnt_raw;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_d_won (last_d_won),
`endif
    .if_gnt     (if_gnt_raw),
    .d_gnt      (d_gnt_raw)
  );

  // Grants are combinational from requests, so they must be masked while
  // reset is held to keep memory quiet.
  assign if_gnt = rst & if_gnt_raw;
  assign d_gnt  = rst & d_gnt_raw;

  // Read-owner state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OWNER_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next owner and memory port drive. A data write grant leaves no read in
  // flight, so the next state is OWNER_NONE.
  always_comb begin
    state_nxt         = OWNER_NONE;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_enable  = 1'b0;
    if (if_gnt) begin
      state_nxt        = OWNER_IF;
      mem_read_address = if_addr;
    end else if (d_gnt) begin
      if (d_we) begin
        mem_write_address = d_addr;
        mem_write_data    = d_wdata;
        mem_write_enable  = 1'b1;
      end else begin
        state_nxt        = OWNER_D;
        mem_read_address = d_addr;
      end
    end
  end

  // Return path: memory data is valid in the cycle after the read grant,
  // which is exactly when the state names the owner.
  assign if_rvalid = (state == OWNER_IF);
  assign d_rvalid  = (state == OWNER_D);
  assign busy      = (state != OWNER_NONE);
  assign if_rdata  = if_rvalid ? mem_read_data : '0;
  assign d_rdata   = d_rvalid  ? mem_read_data : '0;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a one-cycle-latency
// memory model. Inputs change and outputs are sampled around the falling edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_read_address, mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  // Memory model with a bench-side preload port (single writer process).
  logic [DATA_W-1:0] mem [256];
  logic              pre_we = 1'b0;
  logic [7:0]        pre_addr = 8'd0;
  logic [DATA_W-1:0] pre_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_write_address[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_read_address[7:0]];
  end

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_addr = 32'h8;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl: got %b want 00000", {if_gnt, d_gnt, if_rvalid, d_rvalid, busy});
    end
    checks++;
    if ({mem_read_address, mem_write_address, mem_write_data, mem_write_enable, if_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_mem: ra=%h wa=%h wd=%h we=%b", mem_read_address, mem_write_address, mem_write_data, mem_write_enable);
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({if_gnt, d_gnt, mem_write_enable} !== 3'b0 || mem_read_address !== '0 || mem_write_address !== '0) begin
      errors++; $display("FAIL idle_no_grant: gnt=%b%b we=%b ra=%h", if_gnt, d_gnt, mem_write_enable, mem_read_address);
    end
  endtask

  task automatic test_fetch_single();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_read_address !== 32'h10 || mem_write_enable !== 1'b0) begin
      errors++; $display("FAIL fetch_grant: gnt=%b ra=%h want 1 00000010", if_gnt, mem_read_address);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || busy !== 1'b1 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_data: rv=%b rd=%h busy=%b want 1 deadbeef 1", if_rvalid, if_rdata, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b0 || if_rdata !== '0) begin
      errors++; $display("FAIL fetch_done: rv=%b busy=%b rd=%h want 0 0 0", if_rvalid, busy, if_rdata);
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    #1;
    checks++;
    if (d_gnt !== 1'b1 || mem_write_enable !== 1'b1 || mem_write_address !== 32'h20 ||
        mem_write_data !== 32'h12345678 || mem_read_address !== '0) begin
      errors++; $display("FAIL wr_grant: gnt=%b we=%b wa=%h wd=%h ra=%h", d_gnt, mem_write_enable, mem_write_address, mem_write_data, mem_read_address);
    end
    @(negedge clk);
    d_we = 1'b0;
    #1;
    checks++;
    if (d_gnt !== 1'b1 || mem_write_enable !== 1'b0 || mem_read_address !== 32'h20 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_after_wr_grant: gnt=%b we=%b ra=%h rv=%b busy=%b", d_gnt, mem_write_enable, mem_read_address, d_rvalid, busy);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || if_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_after_wr_data: rv=%b rd=%h want 1 12345678", d_rvalid, d_rdata);
    end
  endtask

  // Both requesters hold a read for four cycles, then data drops.
  task automatic test_conflict();
    logic [3:0] exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_d = 4'b0101;  // bit i = cycle i: D, IF, D, IF
`else
    exp_d = 4'b1111;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      #1;
      checks++;
      if (d_gnt !== exp_d[i] || if_gnt !== ~exp_d[i]) begin
        errors++; $display("FAIL conflict_c%0d: d_gnt=%b if_gnt=%b want d_gnt=%b", i, d_gnt, if_gnt, exp_d[i]);
      end
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL conflict_release: if_gnt=%b d_gnt=%b want 1 0", if_gnt, d_gnt);
    end
    checks++;
    if (d_rvalid !== exp_d[3] || d_rdata !== (exp_d[3] ? 32'hC0FFEE00 : 32'h0)) begin
      errors++; $display("FAIL conflict_rdata: d_rv=%b d_rd=%h", d_rvalid, d_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_in_flight();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h11;
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hA5A55A5A) begin
      errors++; $display("FAIL rif_pre: rv=%b rd=%h want 1 a5a55a5a", if_rvalid, if_rdata);
    end
    rst = 1'b0;
    if_req = 1'b1;
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || busy !== 1'b0 || if_rdata !== '0 || if_gnt !== 1'b0) begin
      errors++; $display("FAIL rif_async: rv=%b busy=%b rd=%h gnt=%b want all 0", if_rvalid, busy, if_rdata, if_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rif_stray: if_rv=%b d_rv=%b busy=%b want 0", if_rvalid, d_rvalid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] exp_data [3];
    exp_data[0] = 32'h1111_0000;
    exp_data[1] = 32'h2222_0001;
    exp_data[2] = 32'h3333_0002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = (i < 3);
      if_addr = (i < 3) ? i : 0;
      #1;
      if (i < 3) begin
        checks++;
        if (if_gnt !== 1'b1 || mem_read_address !== i) begin
          errors++; $display("FAIL b2b_gnt%0d: gnt=%b ra=%h", i, if_gnt, mem_read_address);
        end
      end
      if (i > 0) begin
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== exp_data[i-1]) begin
          errors++; $display("FAIL b2b_data%0d: rv=%b rd=%h want 1 %h", i - 1, if_rvalid, if_rdata, exp_data[i-1]);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || if_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: busy=%b rv=%b want 0 0", busy, if_rvalid);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    preload(8'h10, 32'hDEADBEEF);
    preload(8'h11, 32'hA5A55A5A);
    preload(8'h30, 32'hC0FFEE00);
    preload(8'h00, 32'h1111_0000);
    preload(8'h01, 32'h2222_0001);
    preload(8'h02, 32'h3333_0002);
    test_idle();
    test_fetch_single();
    test_write_then_read();
    test_conflict();
    test_reset_in_flight();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter
